// File: rtl/control_unit_if.sv
// Sequencer-to-datapath/memory bundle for the ARM1 control unit.
// The master is the sequencer; the slave is the memory plus the A/B/OUT datapath.
interface control_unit_if #(
    parameter int ADDR_W = 4
);
    logic              pause;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic              a_load;
    logic              a_src;
    logic              b_load;
    logic              out_load;
    logic [1:0]        alu_op;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic              halted;
    logic              instr_done;

    modport master (
        input  pause, mem_rdata,
        output mem_addr, mem_write, a_load, a_src, b_load, out_load,
               alu_op, pc, ir, halted, instr_done
    );

    modport slave (
        output pause, mem_rdata,
        input  mem_addr, mem_write, a_load, a_src, b_load, out_load,
               alu_op, pc, ir, halted, instr_done
    );
endinterface

// File: rtl/control_unit.sv
// Fixed 3-cycle sequencer. state | meaning: FETCH load ir, bump pc | DECODE settle |
// EXEC fire the one datapath/memory strobe | HALT stopped until reset.
module control_unit #(
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    control_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [3:0]        opcode;

    assign opcode = ir_q[7:4];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (!bus.pause) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (opcode == 4'hF) ? S_HALT : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes decode straight from state, so an async reset kills them mid-cycle.
    always_comb begin
        bus.mem_addr   = pc_q;
        bus.mem_write  = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_src      = 1'b0;
        bus.b_load     = 1'b0;
        bus.out_load   = 1'b0;
        bus.instr_done = 1'b0;
        if (state_q == S_EXEC) begin
            bus.mem_addr   = ir_q[ADDR_W-1:0];
            bus.instr_done = 1'b1;
            case (opcode)
                4'h0, 4'h1, 4'h2, 4'h3: bus.a_load = 1'b1;
                4'hA: bus.out_load = 1'b1;
                4'hC: begin
                    bus.a_load = 1'b1;
                    bus.a_src  = 1'b1;
                end
                4'hD: bus.b_load = 1'b1;
                4'hE: bus.mem_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.alu_op = ir_q[5:4];
    assign bus.pc     = pc_q;
    assign bus.ir     = ir_q;
    assign bus.halted = (state_q == S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: pairs it with a 16x8 memory and an A/B/OUT datapath model.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause = 1'b0;
    logic load_req = 1'b0;
    logic gap_chk = 1'b0;

    always #5 clk = ~clk;

    control_unit_if #(.ADDR_W(4)) bus ();
    assign bus.pause = pause;

    logic [7:0] mem [16];
    logic [7:0] img [16];
    logic [7:0] a_q, b_q, out_q;

    assign bus.mem_rdata = mem[bus.mem_addr];

    control_unit #(.ADDR_W(4), .RESET_PC(4'd0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= img[i];
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= a_q;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            out_q <= 8'h00;
        end else begin
            if (bus.a_load) a_q <= bus.a_src ? bus.mem_rdata : alu(bus.alu_op, a_q, b_q);
            if (bus.b_load) b_q <= bus.mem_rdata;
            if (bus.out_load) out_q <= a_q;
        end
    end

    int edge_cnt, done_cnt, halt_edge, last_done, gap_err, overlap_err;

    always @(posedge clk) begin
        if (rst) begin
            edge_cnt    = 0;
            done_cnt    = 0;
            halt_edge   = 0;
            last_done   = 0;
            gap_err     = 0;
            overlap_err = 0;
        end else begin
            if (bus.halted && halt_edge == 0) halt_edge = edge_cnt;
            if ($countones({bus.a_load, bus.b_load, bus.mem_write, bus.out_load}) > 1) overlap_err++;
            if (bus.instr_done) begin
                done_cnt++;
                if (gap_chk && last_done != 0 && edge_cnt - last_done != 3) gap_err++;
                last_done = edge_cnt;
            end
            edge_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Image is copied into memory on the one edge spent in reset; release lands on a negedge.
    task automatic do_reset();
        rst      = 1'b1;
        pause    = 1'b0;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic default_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        img[0]  = 8'hCC;
        img[1]  = 8'hDD;
        img[2]  = 8'h00;
        img[3]  = 8'h20;
        img[4]  = 8'hEE;
        img[5]  = 8'hA0;
        img[6]  = 8'hF0;
        img[12] = 8'h05;
        img[13] = 8'h03;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish before it");
        $fatal(1);
    end

    initial begin
        // Default program, no pause
        default_img();
        do_reset();
        check_eq("rst_pc", bus.pc, 0);
        check_eq("rst_ir", bus.ir, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_strobes", {bus.mem_write, bus.a_load, bus.a_src, bus.b_load, bus.out_load}, 0);
        check_eq("rst_alu_op", bus.alu_op, 0);
        check_eq("rst_flags", {bus.halted, bus.instr_done}, 0);
        tick(2);
        check_eq("lda_exec", {bus.a_load, bus.a_src, bus.instr_done}, 3'b111);
        check_eq("lda_addr", bus.mem_addr, 12);
        check_eq("lda_ir", bus.ir, 8'hCC);
        tick(1);
        check_eq("a_after_lda", a_q, 8'h05);
        tick(6);
        check_eq("a_after_add", a_q, 8'h08);
        tick(2);
        check_eq("or_exec", {bus.a_load, bus.a_src, bus.alu_op}, 4'b1010);
        tick(1);
        check_eq("a_after_or", a_q, 8'h0B);
        tick(2);
        check_eq("str_exec", {bus.mem_write, bus.mem_addr}, 5'h1E);
        tick(6);
        check_eq("halted_e20", bus.halted, 0);
        tick(1);
        check_eq("halted_e21", bus.halted, 1);
        check_eq("halt_pc", bus.pc, 7);
        check_eq("halt_addr", bus.mem_addr, 7);
        check_eq("mem14", mem[14], 8'h0B);
        check_eq("out_reg", out_q, 8'h0B);
        check_eq("b_reg", b_q, 8'h03);
        tick(1);
        check_eq("halt_edge", halt_edge, 21);
        check_eq("done_cnt", done_cnt, 7);
        check_eq("overlap", overlap_err, 0);

        // Pause for 5 cycles in FETCH of instruction 2
        do_reset();
        tick(3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("pause_pc", bus.pc, 1);
            check_eq("pause_ir", bus.ir, 8'hCC);
        end
        pause = 1'b0;
        tick(17);
        check_eq("p_halted_e25", bus.halted, 0);
        tick(1);
        check_eq("p_halted_e26", bus.halted, 1);
        tick(1);
        check_eq("p_halt_edge", halt_edge, 26);
        check_eq("p_a", a_q, 8'h0B);
        check_eq("p_mem14", mem[14], 8'h0B);
        check_eq("p_out", out_q, 8'h0B);
        check_eq("p_done_cnt", done_cnt, 7);

        // Async reset in the EXEC cycle of STR 14
        do_reset();
        tick(14);
        check_eq("pre_rst_str", {bus.mem_write, bus.mem_addr}, 5'h1E);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_str_wr", bus.mem_write, 0);
        check_eq("rst_str_addr", bus.mem_addr, 0);
        check_eq("rst_str_pc", bus.pc, 0);
        check_eq("rst_str_done", bus.instr_done, 0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mem14", mem[14], 8'h00);
        check_eq("rst_rel_pc", bus.pc, 0);
        check_eq("rst_rel_ir", bus.ir, 0);

        // 16 NOPs, PC wrap
        for (int i = 0; i < 16; i++) img[i] = 8'h40;
        do_reset();
        gap_chk = 1'b1;
        tick(45);
        check_eq("wrap_pc15", bus.pc, 15);
        tick(1);
        check_eq("wrap_pc0", bus.pc, 0);
        check_eq("wrap_ir", bus.ir, 8'h40);
        tick(3);
        check_eq("nop_done_cnt", done_cnt, 16);
        check_eq("nop_gap", gap_err, 0);
        check_eq("nop_halted", bus.halted, 0);
        check_eq("nop_a", a_q, 0);
        gap_chk = 1'b0;

        // Undefined opcode 0x50 then HLT
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        img[0] = 8'h50;
        img[1] = 8'hF0;
        do_reset();
        tick(2);
        check_eq("undef_strobes", {bus.a_load, bus.b_load, bus.mem_write, bus.out_load}, 0);
        check_eq("undef_done", bus.instr_done, 1);
        check_eq("undef_addr", bus.mem_addr, 0);
        tick(4);
        check_eq("undef_halted", bus.halted, 1);
        for (int i = 0; i < 20; i++) begin
            pause = ~pause;
            tick(1);
            check_eq("hold_halt", {bus.halted, bus.instr_done, bus.pc}, 6'b10_0010);
        end
        pause = 1'b0;
        check_eq("undef_halt_edge", halt_edge, 6);
        check_eq("undef_ab", {a_q, b_q}, 0);
        check_eq("undef_mem0", mem[0], 8'h50);
        check_eq("undef_done_cnt", done_cnt, 2);
        check_eq("undef_overlap", overlap_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
